// File: rtl/fp_add_arbiter.sv
// Two-requester front end for one shared FP adder: round-robin grant, one op in flight, timeout abort.
// Latency accept->response = 3 + adder latency cycles; ready only in IDLE, so requesters stall while busy.
module fp_add_arbiter #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_op,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_res,
  output logic        resp_err,
  output logic [31:0] fpa_A,
  output logic [31:0] fpa_B,
  output logic        fpa_op,
  output logic        fpa_start,
  input  logic        fpa_done,
  input  logic [31:0] fpa_res
);

  localparam int CW = (TIMEOUT > 63) ? $clog2(TIMEOUT + 1) : 6;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fpa_a_q, fpa_a_d;
  logic [31:0]   fpa_b_q, fpa_b_d;
  logic          fpa_op_q, fpa_op_d;
  logic          fpa_start_q, fpa_start_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   resp_res_q, resp_res_d;
  logic          resp_err_q, resp_err_d;
  logic          resp0_valid_q, resp0_valid_d;
  logic          resp1_valid_q, resp1_valid_d;

  logic          grant0, grant1;
  logic [CW-1:0] cnt_inc;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign cnt_inc = (wait_cnt_q == {CW{1'b1}}) ? wait_cnt_q : wait_cnt_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    fpa_a_d       = fpa_a_q;
    fpa_b_d       = fpa_b_q;
    fpa_op_d      = fpa_op_q;
    fpa_start_d   = 1'b0;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    wait_cnt_d    = wait_cnt_q;
    resp_res_d    = resp_res_q;
    resp_err_d    = resp_err_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          fpa_a_d      = grant1 ? req1_a  : req0_a;
          fpa_b_d      = grant1 ? req1_b  : req0_b;
          fpa_op_d     = grant1 ? req1_op : req0_op;
          owner_d      = grant1;
          last_grant_d = grant1;
          fpa_start_d  = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // Completion wins over a timeout landing on the same cycle.
        if (fpa_done) begin
          resp_res_d    = fpa_res;
          resp_err_d    = 1'b0;
          resp0_valid_d = !owner_q;
          resp1_valid_d = owner_q;
          state_d       = RESP;
        end else begin
          wait_cnt_d = cnt_inc;
          if (cnt_inc >= TO_V) begin
            resp_res_d    = QNAN;
            resp_err_d    = 1'b1;
            resp0_valid_d = !owner_q;
            resp1_valid_d = owner_q;
            state_d       = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fpa_a_q       <= '0;
      fpa_b_q       <= '0;
      fpa_op_q      <= 1'b0;
      fpa_start_q   <= 1'b0;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      wait_cnt_q    <= '0;
      resp_res_q    <= '0;
      resp_err_q    <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fpa_a_q       <= fpa_a_d;
      fpa_b_q       <= fpa_b_d;
      fpa_op_q      <= fpa_op_d;
      fpa_start_q   <= fpa_start_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      wait_cnt_q    <= wait_cnt_d;
      resp_res_q    <= resp_res_d;
      resp_err_q    <= resp_err_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign fpa_A       = fpa_a_q;
  assign fpa_B       = fpa_b_q;
  assign fpa_op      = fpa_op_q;
  assign fpa_start   = fpa_start_q;
  assign resp_res    = resp_res_q;
  assign resp_err    = resp_err_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: the bench plays the shared adder and scoreboards responses against directed vectors.
module tb_fp_add_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid, resp_err;
  logic [31:0] resp_res, fpa_A, fpa_B;
  logic        fpa_op, fpa_start;
  logic        model_done, stim_done;
  logic [31:0] model_res;
  logic        fpa_done_w;

  assign fpa_done_w = model_done | stim_done;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    int          lat;
  } add_t;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] res;
    logic        err;
    int          delta;
  } rsp_t;

  add_t add_q[$];
  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   acc_cnt = 0;
  int   rsp_cnt = 0;

  fp_add_arbiter #(.TIMEOUT(40)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_res(resp_res), .resp_err(resp_err),
    .fpa_A(fpa_A), .fpa_B(fpa_B), .fpa_op(fpa_op), .fpa_start(fpa_start),
    .fpa_done(fpa_done_w), .fpa_res(model_res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no/unexpected event expected none/event", nm);
  endtask

  // Adder model: checks the operands launched and answers after the listed latency (-1 = never).
  initial begin
    add_t e;
    model_done = 1'b0;
    model_res  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && fpa_start) begin
        start_cyc = cyc;
        if (add_q.size() == 0) begin
          fail("unexpected_start");
        end else begin
          e = add_q.pop_front();
          check("fpa_A", fpa_A, e.a);
          check("fpa_B", fpa_B, e.b);
          check("fpa_op", {31'b0, fpa_op}, {31'b0, e.op});
          if (e.lat > 0) begin
            @(posedge clk);
            repeat (e.lat - 1) @(posedge clk);
            #1 model_done = 1'b1;
            model_res = e.res;
            @(posedge clk);
            #1 model_done = 1'b0;
          end
        end
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && req0_valid && req0_ready) acc_cnt++;
      if (rst_n && req1_valid && req1_ready) acc_cnt++;
      if (resp0_valid || resp1_valid) begin
        rsp_cnt++;
        if (sb_q.size() == 0) begin
          fail("unexpected_resp");
        end else begin
          e = sb_q.pop_front();
          check("resp_port", {30'b0, resp1_valid, resp0_valid}, {30'b0, e.port});
          check("resp_res", resp_res, e.res);
          check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          check("resp_latency", 32'(cyc - start_cyc), 32'(e.delta));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [31:0] a, input logic [31:0] b, input logic op);
    int g;
    if (n == 0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!((n == 0) ? req0_ready : req1_ready) && g < 200);
    if (!((n == 0) ? req0_ready : req1_ready)) fail("send_timeout");
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int g;
    int r;
    rst_n = 1'b0; stim_done = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_op = 1'b0; req1_op = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fpa_start", {31'b0, fpa_start}, 32'd0);
    check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    check("rst_resp0_valid", {31'b0, resp0_valid}, 32'd0);
    check("rst_resp1_valid", {31'b0, resp1_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_res", resp_res, 32'd0);
    check("rst_fpa_A", fpa_A, 32'd0);
    check("rst_fpa_B", fpa_B, 32'd0);
    check("rst_fpa_op", {31'b0, fpa_op}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters valid continuously: grants 0,1,0,1 (1+1=2, 2-1=1).
    add_q.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2});
    add_q.push_back('{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 2});
    add_q.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2});
    add_q.push_back('{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 2});
    sb_q.push_back('{2'b01, 32'h40000000, 1'b0, 3});
    sb_q.push_back('{2'b10, 32'h3F800000, 1'b0, 3});
    sb_q.push_back('{2'b01, 32'h40000000, 1'b0, 3});
    sb_q.push_back('{2'b10, 32'h3F800000, 1'b0, 3});
    req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_op = 1'b0;
    req1_a = 32'h40000000; req1_b = 32'h3F800000; req1_op = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    g = 0;
    while (acc_cnt < 4 && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (acc_cnt < 4) fail("alternate_accept_timeout");
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle(20);
    check("drain_alternate", 32'(sb_q.size()), 32'd0);

    // 1.0 + 2.0 = 3.0, adder latency 3.
    add_q.push_back('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3});
    sb_q.push_back('{2'b01, 32'h40400000, 1'b0, 4});
    send(0, 32'h3F800000, 32'h40000000, 1'b0);
    idle(10);
    check("drain_add", 32'(sb_q.size()), 32'd0);

    // 5.0 - 5.0 = +0.0 on requester 1.
    add_q.push_back('{32'h40A00000, 32'h40A00000, 1'b1, 32'h00000000, 1});
    sb_q.push_back('{2'b10, 32'h00000000, 1'b0, 2});
    send(1, 32'h40A00000, 32'h40A00000, 1'b1);
    idle(8);
    check("drain_sub", 32'(sb_q.size()), 32'd0);

    // Adder never answers: quiet NaN with error after 40 WAIT cycles.
    add_q.push_back('{32'h3F800000, 32'hBF800000, 1'b0, 32'h0, -1});
    sb_q.push_back('{2'b10, 32'h7FC00000, 1'b1, 41});
    send(1, 32'h3F800000, 32'hBF800000, 1'b0);
    idle(50);
    check("drain_timeout", 32'(sb_q.size()), 32'd0);

    // Done on the very cycle the counter hits TIMEOUT: 3.0 - 1.0 = 2.0, no error.
    add_q.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 40});
    sb_q.push_back('{2'b01, 32'h40000000, 1'b0, 41});
    send(0, 32'h40400000, 32'h3F800000, 1'b1);
    idle(50);
    check("drain_done_at_timeout", 32'(sb_q.size()), 32'd0);

    // Reset mid-WAIT, then a stray done: no response may appear.
    add_q.push_back('{32'h40000000, 32'h40000000, 1'b0, 32'h0, -1});
    r = rsp_cnt;
    send(0, 32'h40000000, 32'h40000000, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    stim_done = 1'b1;
    @(posedge clk);
    #1 stim_done = 1'b0;
    idle(10);
    check("reset_no_resp", 32'(rsp_cnt), 32'(r));
    check("reset_add_q", 32'(add_q.size()), 32'd0);

    // After reset req0 wins a tie.
    add_q.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1});
    sb_q.push_back('{2'b01, 32'h00000000, 1'b0, 2});
    req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_op = 1'b1;
    req1_a = 32'h40000000; req1_b = 32'h40000000; req1_op = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("tie_req0_ready", {31'b0, req0_ready}, 32'd1);
    check("tie_req1_ready", {31'b0, req1_ready}, 32'd0);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle(10);
    check("drain_tie", 32'(sb_q.size()), 32'd0);
    check("drain_adder", 32'(add_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40: maximum number of WAIT cycles before an operation is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester N presents an operation.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b, input, 32 bits each: IEEE-754 single-precision operands.
REQ-006 SHALL have ports req0_op / req1_op, input, 1 bit each: 0 = add, 1 = subtract (A-B).
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 bit each: the request is accepted on a cycle where valid and ready are both 1.
REQ-008 SHALL have ports resp0_valid / resp1_valid, output, 1 bit each: one-cycle result pulse to requester N.
REQ-009 SHALL have port resp_res, output, 32 bits: result word, meaningful only while a respN_valid is high.
REQ-010 SHALL have port resp_err, output, 1 bit: set with respN_valid when the operation timed out.
REQ-011 SHALL have ports fpa_A, fpa_B, output, 32 bits each, and fpa_op, output, 1 bit: operands and operation driven to the shared adder.
REQ-012 SHALL have port fpa_start, output, 1 bit: one-cycle launch pulse to the adder.
REQ-013 SHALL have port fpa_done, input, 1 bit, and fpa_res, input, 32 bits: adder completion flag and its result.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP; the encoding is free.
REQ-015 SHALL assert no ready signal outside IDLE; no request is accepted while an operation is in flight.
REQ-016 SHALL, in IDLE, drive ready combinationally to at most one requester: only req0_valid -> req0_ready; only req1_valid -> req1_ready; both valid -> the requester not recorded in last_grant.
REQ-017 SHALL, on acceptance, register a, b and op into fpa_A/fpa_B/fpa_op, record the granted index in owner and last_grant, and move to ISSUE.
REQ-018 SHALL hold fpa_A/fpa_B/fpa_op stable from ISSUE through the end of WAIT.
REQ-019 SHALL, in ISSUE, assert fpa_start for exactly one cycle, clear the wait counter to 0, and move to WAIT.
REQ-020 SHALL, in WAIT, ignore fpa_done in the ISSUE cycle itself and sample it from the first WAIT cycle onward.
REQ-021 SHALL, in WAIT with fpa_done=1, capture fpa_res into resp_res, clear resp_err and move to RESP.
REQ-022 SHALL, in WAIT with fpa_done=0, increment the wait counter (6-bit minimum, saturating); when the counter reaches TIMEOUT it SHALL set resp_res=0x7FC00000, set resp_err=1 and move to RESP.
REQ-023 SHALL, when fpa_done=1 on the same cycle the counter reaches TIMEOUT, take the done path: no error, adder result used.
REQ-024 SHALL, in RESP, pulse resp<owner>_valid for one cycle and return to IDLE; the other resp valid stays 0.
REQ-025 SHALL produce a best-case latency of 4 cycles (accept, ISSUE, first WAIT with done, RESP); each extra cycle of adder latency adds one cycle.
REQ-026 SHALL allow a new acceptance in the IDLE cycle immediately following RESP, giving back-to-back throughput of one operation per (3 + adder latency) cycles.
REQ-027 SHALL ignore a requester dropping valid after acceptance; the operation completes and responds normally.
REQ-028 SHALL ignore fpa_done whenever the FSM is not in WAIT.

Reset
REQ-029 SHALL, with rst_n=0 at a clock edge, enter IDLE and clear fpa_start, both ready, both resp valid, resp_err, resp_res, fpa_A, fpa_B, fpa_op, owner, the wait counter and last_grant (last_grant=1, so req0 wins the first tie).
REQ-030 SHALL, on reset during ISSUE/WAIT/RESP, abandon the operation with no response pulse and ignore any later fpa_done until a new ISSUE.

Verification
REQ-031 SHALL be checked by: req0 0x3F800000 + 0x40000000, op=0, adder done 3 cycles after start -> fpa_start once, resp0_valid pulse, resp_res=0x40400000, resp_err=0, resp1_valid=0.
REQ-032 SHALL be checked by: req0 and req1 both valid continuously after reset -> grants alternate 0,1,0,1; each response goes only to its owner.
REQ-033 SHALL be checked by: a request with fpa_done never asserted, TIMEOUT=40 -> resp pulse 40 WAIT cycles after ISSUE with resp_res=0x7FC00000, resp_err=1.
REQ-034 SHALL be checked by: fpa_done asserted on the cycle the counter reaches TIMEOUT -> adder result returned, resp_err=0.
REQ-035 SHALL be checked by: rst_n=0 for one cycle mid-WAIT, then fpa_done pulsed -> no resp pulse, FSM in IDLE, req0_ready=1 when req0_valid=1.
REQ-036 SHALL be checked by: req1 operands 0x40A00000 - 0x40A00000, op=1 -> resp1 result 0x00000000, resp_err=0.
